// File: rtl/traffic_ctrl_nway_pkg.sv
// Shared phase/lamp encodings and width helpers for the N-way traffic controller.
// Imported by the interface, the arbiter and the top level.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;

    localparam logic [1:0] LT_GREEN  = 2'd0;
    localparam logic [1:0] LT_YELLOW = 2'd1;
    localparam logic [1:0] LT_RED    = 2'd2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int way_width(input int num_ways);
        return (num_ways > 2) ? $clog2(num_ways) : 1;
    endfunction

    // A counter that must reach max_val-1 needs clog2(max_val) bits, never fewer than one.
    function automatic int cnt_width(input int max_val);
        return (max_val > 2) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/traffic_ctrl_nway_if.sv
// Bundle of the controller's request input and lamp/status outputs.
// The controller uses the slave view, the intersection driver the master view.
interface traffic_ctrl_nway_if #(
    parameter int NUM_WAYS = 4
) ();
    import traffic_pkg::*;

    localparam int WAY_W = way_width(NUM_WAYS);

    logic [NUM_WAYS-1:0]   req;
    logic [2*NUM_WAYS-1:0] lights;
    logic [WAY_W-1:0]      active_way;
    logic [1:0]            phase;

    modport master (
        output req,
        input  lights,
        input  active_way,
        input  phase
    );

    modport slave (
        input  req,
        output lights,
        output active_way,
        output phase
    );

endinterface

// File: rtl/traffic_ctrl_nway_rr_next_way.sv
// Combinational cyclic priority search: first set request strictly after the current way.
// When nothing else is requesting, the grant falls back to the current way.
module rr_next_way #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = 2
) (
    input  logic [NUM_WAYS-1:0] i_req,
    input  logic [WAY_W-1:0]    i_cur,
    output logic [WAY_W-1:0]    o_grant,
    output logic                o_found
);
    logic [WAY_W-1:0] w_idx [1:NUM_WAYS-1];
    logic             w_hit [1:NUM_WAYS-1];

    genvar gi;
    generate
        for (gi = 1; gi < NUM_WAYS; gi++) begin : g_cand
            assign w_idx[gi] = WAY_W'((int'(i_cur) + gi) % NUM_WAYS);
            assign w_hit[gi] = i_req[w_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        o_grant = i_cur;
        o_found = 1'b0;
        for (int k = NUM_WAYS - 1; k >= 1; k--) begin
            if (w_hit[k]) begin
                o_grant = w_idx[k];
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// N-way traffic-light controller: GREEN/YELLOW/ALLRED Moore FSM with min/max green
// timing and round-robin selection of the next approach.
module traffic_ctrl_nway
    import traffic_pkg::*;
#(
    parameter int NUM_WAYS      = 4,
    parameter int GREEN_MIN     = 8,
    parameter int GREEN_MAX     = 32,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    traffic_ctrl_nway_if.slave  bus
);
    localparam int WAY_W = way_width(NUM_WAYS);
    localparam int CNT_W = cnt_width(max3(GREEN_MAX, YELLOW_CYCLES, ALLRED_CYCLES));

    localparam logic [CNT_W-1:0] C_GREEN_MIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GREEN_MAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YELLOW_LAST    = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ALLRED_LAST    = CNT_W'(ALLRED_CYCLES - 1);

    phase_e                r_phase;
    logic [CNT_W-1:0]      r_cnt;
    logic [WAY_W-1:0]      r_active_way;

    logic [NUM_WAYS-1:0]   w_req;
    logic [WAY_W-1:0]      w_grant;
    logic                  w_other_req;
    logic                  w_own_req;
    logic                  w_green_done;
    logic [2*NUM_WAYS-1:0] w_lights;

    assign w_req     = bus.req;
    assign w_own_req = w_req[r_active_way];

    // The arbiter's found flag is exactly "some other way is requesting".
    rr_next_way #(
        .NUM_WAYS (NUM_WAYS),
        .WAY_W    (WAY_W)
    ) u_rr_next_way (
        .i_req   (w_req),
        .i_cur   (r_active_way),
        .o_grant (w_grant),
        .o_found (w_other_req)
    );

    assign w_green_done = (r_cnt >= C_GREEN_MIN_LAST) && w_other_req &&
                          (!w_own_req || (r_cnt == C_GREEN_MAX_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= PH_GREEN;
            r_cnt        <= '0;
            r_active_way <= '0;
        end else begin
            case (r_phase)
                PH_GREEN: begin
                    if (w_green_done) begin
                        r_phase <= PH_YELLOW;
                        r_cnt   <= '0;
                    end else if (r_cnt != C_GREEN_MAX_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (r_cnt == C_YELLOW_LAST) begin
                        r_phase <= PH_ALLRED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_ALLRED: begin
                    if (r_cnt == C_ALLRED_LAST) begin
                        r_phase      <= PH_GREEN;
                        r_cnt        <= '0;
                        r_active_way <= w_grant;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_phase <= PH_GREEN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Lamp decode depends only on registered state, so req never reaches the lamps combinationally.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_lamp
            assign w_lights[2*gi +: 2] =
                (r_active_way != WAY_W'(gi)) ? LT_RED    :
                (r_phase == PH_GREEN)        ? LT_GREEN  :
                (r_phase == PH_YELLOW)       ? LT_YELLOW : LT_RED;
        end
    endgenerate

    assign bus.lights     = w_lights;
    assign bus.active_way = r_active_way;
    assign bus.phase      = r_phase;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// Directed self-checking bench for traffic_ctrl_nway at default parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_traffic_ctrl_nway;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    traffic_ctrl_nway_if #(.NUM_WAYS(4)) tif ();

    traffic_ctrl_nway #(
        .NUM_WAYS      (4),
        .GREEN_MIN     (8),
        .GREEN_MAX     (32),
        .YELLOW_CYCLES (3),
        .ALLRED_CYCLES (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds reset across two edges, then releases it 1 unit after an edge with req applied.
    // On return the current sample is the first green cycle (cnt = 0).
    task automatic do_reset(input logic [3:0] r);
        reset_n  = 1'b0;
        tif.req  = 4'b0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tif.req  = r;
        reset_n  = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tif.req = 4'b0000;
        #1;
        checks++;
        if (tif.lights !== 8'hA8 || tif.phase !== 2'd0 || tif.active_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_initial: lights=%h phase=%0d way=%0d required lights=a8 phase=0 way=0",
                     tif.lights, tif.phase, tif.active_way);
        end
        do_reset(4'b1111);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tif.active_way !== 2'd1 || tif.phase !== 2'd0 || tif.lights !== 8'hA2) begin
            failures++;
            $display("FAIL reset_prerun: lights=%h phase=%0d way=%0d required lights=a2 phase=0 way=1",
                     tif.lights, tif.phase, tif.active_way);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (tif.lights !== 8'hA8 || tif.phase !== 2'd0 || tif.active_way !== 2'd0) begin
            failures++;
            $display("FAIL reset_async: lights=%h phase=%0d way=%0d required lights=a8 phase=0 way=0",
                     tif.lights, tif.phase, tif.active_way);
        end
        $display("test_reset done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_no_demand();
        do_reset(4'b0000);
        for (int i = 0; i < 200; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (tif.lights !== 8'hA8 || tif.phase !== 2'd0) begin
                failures++;
                $display("FAIL no_demand cycle %0d: lights=%h phase=%0d required lights=a8 phase=0",
                         i, tif.lights, tif.phase);
            end
        end
        $display("test_no_demand done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_own_request_only();
        do_reset(4'b0001);
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++;
            if (tif.lights !== 8'hA8 || tif.phase !== 2'd0) begin
                failures++;
                $display("FAIL own_req_hold cycle %0d: lights=%h phase=%0d required lights=a8 phase=0",
                         i, tif.lights, tif.phase);
            end
        end
        $display("test_own_request_only done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_min_green();
        logic [1:0] exp_phase;
        logic [1:0] exp_way;
        logic [7:0] exp_lights;
        do_reset(4'b0100);
        for (int i = 0; i <= 13; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i < 8)       begin exp_phase = 2'd0; exp_way = 2'd0; exp_lights = 8'hA8; end
            else if (i < 11) begin exp_phase = 2'd1; exp_way = 2'd0; exp_lights = 8'hA9; end
            else if (i < 13) begin exp_phase = 2'd2; exp_way = 2'd0; exp_lights = 8'hAA; end
            else             begin exp_phase = 2'd0; exp_way = 2'd2; exp_lights = 8'h8A; end
            checks++;
            if (tif.phase !== exp_phase || tif.active_way !== exp_way || tif.lights !== exp_lights) begin
                failures++;
                $display("FAIL min_green cycle %0d: phase=%0d way=%0d lights=%h required phase=%0d way=%0d lights=%h",
                         i, tif.phase, tif.active_way, tif.lights, exp_phase, exp_way, exp_lights);
            end
        end
        $display("test_min_green done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_max_green();
        logic [1:0] exp_phase;
        logic [1:0] exp_way;
        do_reset(4'b0011);
        for (int i = 0; i <= 37; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (i < 32)      begin exp_phase = 2'd0; exp_way = 2'd0; end
            else if (i < 35) begin exp_phase = 2'd1; exp_way = 2'd0; end
            else if (i < 37) begin exp_phase = 2'd2; exp_way = 2'd0; end
            else             begin exp_phase = 2'd0; exp_way = 2'd1; end
            checks++;
            if (tif.phase !== exp_phase || tif.active_way !== exp_way) begin
                failures++;
                $display("FAIL max_green cycle %0d: phase=%0d way=%0d required phase=%0d way=%0d",
                         i, tif.phase, tif.active_way, exp_phase, exp_way);
            end
        end
        checks++;
        if (tif.lights !== 8'hA2) begin
            failures++;
            $display("FAIL max_green_lights: lights=%h required a2", tif.lights);
        end
        $display("test_max_green done: checks=%0d failures=%0d", checks, failures);
    endtask

    // Each way holds 32 green + 3 yellow + 2 all-red = 37 cycles before the next way's green.
    task automatic test_round_robin();
        logic [1:0] exp_phase;
        logic [1:0] exp_way;
        int         k;
        int         j;
        do_reset(4'b1111);
        for (int i = 0; i < 37 * 4 + 32; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            k = i / 37;
            j = i % 37;
            exp_way = 2'(k % 4);
            if (j < 32)      exp_phase = 2'd0;
            else if (j < 35) exp_phase = 2'd1;
            else             exp_phase = 2'd2;
            checks++;
            if (tif.phase !== exp_phase || tif.active_way !== exp_way) begin
                failures++;
                $display("FAIL round_robin cycle %0d: phase=%0d way=%0d required phase=%0d way=%0d",
                         i, tif.phase, tif.active_way, exp_phase, exp_way);
            end
        end
        $display("test_round_robin done: checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_vanishing_request();
        int yellow_at;
        yellow_at = -1;
        do_reset(4'b0010);
        for (int i = 0; i < 20 && yellow_at < 0; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (tif.phase === 2'd1) yellow_at = i;
        end
        tif.req = 4'b0000;
        checks++;
        if (yellow_at != 8) begin
            failures++;
            $display("FAIL vanish_yellow_entry: yellow at cycle %0d required cycle 8", yellow_at);
        end
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tif.phase !== 2'd0 || tif.active_way !== 2'd0 || tif.lights !== 8'hA8) begin
            failures++;
            $display("FAIL vanish_return: phase=%0d way=%0d lights=%h required phase=0 way=0 lights=a8",
                     tif.phase, tif.active_way, tif.lights);
        end
        $display("test_vanishing_request done: checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        tif.req  = 4'b0000;
        test_reset();
        test_no_demand();
        test_own_request_only();
        test_min_green();
        test_max_green();
        test_round_robin();
        test_vanishing_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
